hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: multiply busy cycles after issue to EX.
REQ-002 Parameter DIV_CYC, default 10: divide busy cycles after issue to EX.
REQ-003 Parameter CNT_W, default 4: busy-counter width; SHALL hold max(MULT_CYC, DIV_CYC).
REQ-004 clk  in  1  single pipeline clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 IdInstr  in  32  instruction currently in ID.
REQ-007 IdValid  in  1  IdInstr is a real instruction; 0 = bubble.
REQ-008 BranchTaken  in  1  ID-stage beq compare result.
REQ-009 Stall  out  1  freeze PC and IF/ID.
REQ-010 Bubble  out  1  load NOP into ID/EX.
REQ-011 FlushIFID  out  1  clear IF/ID next edge.
REQ-012 JumpToTarget  out  1  PC selects jump/branch target.
REQ-013 FwdRsSel, FwdRtSel  out  2 each  ID operand source: 0 regfile, 1 EX/MEM, 2 MEM/WB.
REQ-014 MdBusy  out  1  mult/div unit occupied.

Function
REQ-015 Decode SHALL cover lw 100011, sw 101011, beq 000100, j 000010, jal 000011, lui 001111, ori 001101; R-type (000000) funct addu 100001, subu 100011, jr 001000, mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; anything else is a NOP.
REQ-016 Internal 3-entry scoreboard (EX, MEM, WB), each {valid, dst[4:0], tnew[1:0]}.
REQ-017 Tnew on EX entry: lw 2; addu/subu/ori/lui/mfhi/mflo 1; jal 0 with dst 31; all others valid=0.
REQ-018 dst: rd for R-type writers, rt for ori/lui/lw, 31 for jal.
REQ-019 Each edge: EX <= decoded ID entry if !Stall && IdValid, else invalid; MEM <= EX with tnew-1 saturating at 0; WB <= MEM with tnew 0.
REQ-020 Tuse: rs 0 for beq/jr, 1 for ALU/lw/sw/mult/div/mthi/mtlo; rt 0 for beq, 1 for addu/subu/mult/div, 2 for sw.
REQ-021 Data stall when a read source is nonzero and matches the dst of a valid entry whose tnew > tuse; the youngest matching entry decides.
REQ-022 MD stall when ID holds mult/div/mfhi/mflo/mthi/mtlo and (MdBusy or EX entry is mult/div).
REQ-023 Stall = data stall OR MD stall; Bubble = Stall.
REQ-024 Forward selection, youngest match first with tnew==0: MEM match -> 1, else WB match -> 2, else 0; register 0 always selects 0.
REQ-025 Busy counter: loaded with MULT_CYC (mult/multu) or DIV_CYC (div/divu) on the edge the op leaves EX; then decrements by 1 to 0; MdBusy = counter != 0.
REQ-026 A new mult/div load while counter != 0 is impossible (REQ-022); the counter SHALL NOT wrap.
REQ-027 JumpToTarget = FlushIFID = 1 when ID holds j/jal/jr, or beq with BranchTaken, and !Stall.
REQ-028 Simultaneous stall and jump: stall wins; jump is asserted on the first non-stalled cycle.
REQ-029 IdValid=0 contributes no hazard, jump or scoreboard entry.

Reset
REQ-030 While reset is high: scoreboard invalid, counter 0; Stall, Bubble, FlushIFID, JumpToTarget, MdBusy all 0; Fwd selects 0.
REQ-031 Reset mid-divide SHALL abort the count immediately; first post-reset ID mfhi is not stalled.

Structure
REQ-032 Shared package holds opcode/funct constants, Tnew/Tuse constants, the Fwd select encoding and the scoreboard entry type.
REQ-033 One sub-module, md_busy_ctr, implements REQ-025/026; everything else lives in hazard_ctrl.

Verification
REQ-034 lw $1 then addu $2,$1,$3 -> Stall=Bubble=1 for exactly 1 cycle, then FwdRsSel=2.
REQ-035 addu $1 then beq $1,$0 -> 1 stall cycle, then FwdRsSel=1, and with BranchTaken=1 JumpToTarget=FlushIFID=1.
REQ-036 div then mflo immediately -> Stall high for DIV_CYC+1 cycles (11 at default), MdBusy high for 10.
REQ-037 jal then jr $31 -> jr sees FwdRsSel=1 with no stall; both jumps assert JumpToTarget for 1 cycle each.
REQ-038 Reset asserted on the 3rd cycle of a mult -> all outputs 0 asynchronously; following mfhi issues with no stall.
REQ-039 Writes to $0 (addu $0 then addu using $0) -> no stall, Fwd selects 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the ID-stage hazard controller: opcode and funct
//   constants, Tnew/Tuse constants, the forwarding-select encoding, the
//   scoreboard entry type and the instruction decode helper.
package hazard_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct codes
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    // Cycles until a result exists (Tnew, counted from the EX entry)
    localparam logic [1:0] TNEW_LW  = 2'd2;
    localparam logic [1:0] TNEW_ALU = 2'd1;
    localparam logic [1:0] TNEW_JAL = 2'd0;

    // Cycles until an operand is consumed (Tuse, counted from ID)
    localparam logic [1:0] TUSE_0 = 2'd0;
    localparam logic [1:0] TUSE_1 = 2'd1;
    localparam logic [1:0] TUSE_2 = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_op_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_entry_t;

    typedef struct packed {
        logic       rs_read;
        logic [1:0] rs_tuse;
        logic       rt_read;
        logic [1:0] rt_tuse;
        sb_entry_t  wr;       // scoreboard entry this instruction creates
        md_op_e     md_op;    // starts the mult/div unit
        logic       md_use;   // any HI/LO or mult/div unit access
        logic       is_jump;  // j / jal / jr
        logic       is_beq;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        op = instr[31:26];
        fn = instr[5:0];
        rt = instr[20:16];
        rd = instr[15:11];
        d = '0;
        d.md_op = MD_NONE;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                        d.rt_read = 1'b1; d.rt_tuse = TUSE_1;
                        d.wr = '{valid: 1'b1, dst: rd, tnew: TNEW_ALU};
                    end
                    FN_JR: begin
                        d.rs_read = 1'b1; d.rs_tuse = TUSE_0;
                        d.is_jump = 1'b1;
                    end
                    FN_MULT, FN_MULTU: begin
                        d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                        d.rt_read = 1'b1; d.rt_tuse = TUSE_1;
                        d.md_op   = MD_MULT;
                        d.md_use  = 1'b1;
                    end
                    FN_DIV, FN_DIVU: begin
                        d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                        d.rt_read = 1'b1; d.rt_tuse = TUSE_1;
                        d.md_op   = MD_DIV;
                        d.md_use  = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        d.md_use = 1'b1;
                        d.wr = '{valid: 1'b1, dst: rd, tnew: TNEW_ALU};
                    end
                    FN_MTHI, FN_MTLO: begin
                        d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                        d.md_use  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                d.wr = '{valid: 1'b1, dst: rt, tnew: TNEW_LW};
            end
            OP_SW: begin
                d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                d.rt_read = 1'b1; d.rt_tuse = TUSE_2;
            end
            OP_BEQ: begin
                d.rs_read = 1'b1; d.rs_tuse = TUSE_0;
                d.rt_read = 1'b1; d.rt_tuse = TUSE_0;
                d.is_beq  = 1'b1;
            end
            OP_J: begin
                d.is_jump = 1'b1;
            end
            OP_JAL: begin
                d.is_jump = 1'b1;
                d.wr = '{valid: 1'b1, dst: REG_RA, tnew: TNEW_JAL};
            end
            OP_LUI: begin
                d.wr = '{valid: 1'b1, dst: rt, tnew: TNEW_ALU};
            end
            OP_ORI: begin
                d.rs_read = 1'b1; d.rs_tuse = TUSE_1;
                d.wr = '{valid: 1'b1, dst: rt, tnew: TNEW_ALU};
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// md_busy_ctr
//   Occupancy counter for the multiply/divide unit. Loaded with the op's
//   latency on the edge the op leaves EX, then counts down to zero.
//   Ports:
//     clk, reset          pipeline clock, async active-high reset
//     load_mult/load_div  a mult / div is in EX this cycle
//     busy                counter is nonzero
module md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_mult,
    input  logic load_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt;

    // A load can only occur once the count has drained (the ID stage holds
    // mult/div while busy), and the decrement stops at zero so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_div) begin
            cnt <= DIV_LD;
        end else if (load_mult) begin
            cnt <= MULT_LD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   ID-stage hazard unit for a 5-stage MIPS-subset pipeline: Tnew/Tuse data
//   stalls, mult/div structural stalls, ID-stage forwarding selects and
//   jump/branch redirect.
//   Ports:
//     clk, reset            pipeline clock, async active-high reset
//     IdInstr, IdValid      instruction in ID and its valid flag
//     BranchTaken           beq compare result from ID
//     Stall, Bubble         freeze PC/IF-ID, insert NOP into ID/EX
//     FlushIFID             clear IF/ID on the next edge
//     JumpToTarget          PC takes the jump/branch target
//     FwdRsSel, FwdRtSel    ID operand source (0 regfile, 1 EX/MEM, 2 MEM/WB)
//     MdBusy                mult/div unit occupied
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IdInstr,
    input  logic        IdValid,
    input  logic        BranchTaken,
    output logic        Stall,
    output logic        Bubble,
    output logic        FlushIFID,
    output logic        JumpToTarget,
    output logic [1:0]  FwdRsSel,
    output logic [1:0]  FwdRtSel,
    output logic        MdBusy
);

    typedef struct packed {
        logic     stall;
        fwd_sel_e fwd;
    } probe_t;

    dec_t       dec;
    sb_entry_t  sb_ex, sb_mem, sb_wb;
    md_op_e     ex_md;
    logic       md_busy;
    probe_t     rs_probe, rt_probe;
    logic       data_stall, md_stall, stall_int, redirect;

    // The youngest scoreboard entry writing src decides: it stalls if its
    // value arrives later than the reader needs it, and it is forwarded only
    // once ready. An older match is stale and never consulted. A ready EX
    // entry (jal link) is read through the EX/MEM path.
    function automatic probe_t probe(input logic [4:0] src, input logic [1:0] tuse,
                                     input sb_entry_t ex, input sb_entry_t mem,
                                     input sb_entry_t wb);
        probe_t p;
        p.stall = 1'b0;
        p.fwd   = FWD_RF;
        if (src != 5'd0) begin
            if (ex.valid && ex.dst == src) begin
                p.stall = (ex.tnew > tuse);
                p.fwd   = (ex.tnew == 2'd0) ? FWD_EXMEM : FWD_RF;
            end else if (mem.valid && mem.dst == src) begin
                p.stall = (mem.tnew > tuse);
                p.fwd   = (mem.tnew == 2'd0) ? FWD_EXMEM : FWD_RF;
            end else if (wb.valid && wb.dst == src) begin
                p.stall = (wb.tnew > tuse);
                p.fwd   = FWD_MEMWB;
            end
        end
        return p;
    endfunction

    assign dec = decode(IdInstr);

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
            ex_md  <= MD_NONE;
        end else begin
            if (IdValid && !stall_int) begin
                sb_ex <= dec.wr;
                ex_md <= dec.md_op;
            end else begin
                sb_ex <= '0;
                ex_md <= MD_NONE;
            end
            sb_mem.valid <= sb_ex.valid;
            sb_mem.dst   <= sb_ex.dst;
            sb_mem.tnew  <= (sb_ex.tnew == 2'd0) ? 2'd0 : sb_ex.tnew - 2'd1;
            sb_wb.valid  <= sb_mem.valid;
            sb_wb.dst    <= sb_mem.dst;
            sb_wb.tnew   <= 2'd0;
        end
    end

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_ctr (
        .clk       (clk),
        .reset     (reset),
        .load_mult (ex_md == MD_MULT),
        .load_div  (ex_md == MD_DIV),
        .busy      (md_busy)
    );

    // Hazard detection
    always_comb begin
        rs_probe   = probe(IdInstr[25:21], dec.rs_tuse, sb_ex, sb_mem, sb_wb);
        rt_probe   = probe(IdInstr[20:16], dec.rt_tuse, sb_ex, sb_mem, sb_wb);
        data_stall = IdValid && ((dec.rs_read && rs_probe.stall) ||
                                 (dec.rt_read && rt_probe.stall));
        md_stall   = IdValid && dec.md_use && (md_busy || ex_md != MD_NONE);
        stall_int  = data_stall || md_stall;
        // A stalled jump waits; it redirects on its first unstalled cycle.
        redirect   = IdValid && !stall_int &&
                     (dec.is_jump || (dec.is_beq && BranchTaken));
    end

    // Outputs are forced quiet while reset is held, including the purely
    // input-driven redirect and forward terms.
    always_comb begin
        Stall        = !reset && stall_int;
        Bubble       = !reset && stall_int;
        JumpToTarget = !reset && redirect;
        FlushIFID    = !reset && redirect;
        MdBusy       = !reset && md_busy;
        FwdRsSel     = (!reset && IdValid && dec.rs_read) ? rs_probe.fwd : FWD_RF;
        FwdRtSel     = (!reset && IdValid && dec.rt_read) ? rt_probe.fwd : FWD_RF;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] IdInstr;
    logic        IdValid;
    logic        BranchTaken;
    logic        Stall, Bubble, FlushIFID, JumpToTarget, MdBusy;
    logic [1:0]  FwdRsSel, FwdRtSel;

    int checks = 0;
    int errors = 0;

    // {Stall, Bubble, FlushIFID, JumpToTarget, FwdRsSel, FwdRtSel, MdBusy}
    logic [8:0] exp_q[$];
    string      tag_q[$];

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .IdInstr      (IdInstr),
        .IdValid      (IdValid),
        .BranchTaken  (BranchTaken),
        .Stall        (Stall),
        .Bubble       (Bubble),
        .FlushIFID    (FlushIFID),
        .JumpToTarget (JumpToTarget),
        .FwdRsSel     (FwdRsSel),
        .FwdRtSel     (FwdRtSel),
        .MdBusy       (MdBusy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction encoders
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op);
        return {op, 26'h0000100};
    endfunction

    function automatic logic [8:0] ev(input logic s, input logic j, input logic [1:0] rs,
                                      input logic [1:0] rt, input logic b);
        return {s, s, j, j, rs, rt, b};
    endfunction

    // driver: one ID cycle per call, inputs applied just after the edge
    task automatic step(input logic rst, input logic [31:0] instr, input logic v,
                        input logic br, input logic [8:0] exp, input string tag);
        @(posedge clk);
        #1;
        reset       = rst;
        IdInstr     = instr;
        IdValid     = v;
        BranchTaken = br;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic bubbles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0), tag);
    endtask

    // scoreboard monitor: compares on the falling edge
    always @(negedge clk) begin
        logic [8:0] got, e;
        string      t;
        if (exp_q.size() > 0) begin
            got = {Stall, Bubble, FlushIFID, JumpToTarget, FwdRsSel, FwdRtSel, MdBusy};
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%b exp=%b (S B F J rs rt busy)", t, got, e);
            end
        end
    end

    localparam logic [5:0] LW = 6'b100011, BEQ = 6'b000100, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] ADDU = 6'b100001, JR = 6'b001000, MULT = 6'b011000;
    localparam logic [5:0] DIV = 6'b011010, MFHI = 6'b010000, MFLO = 6'b010010;

    initial begin
        reset = 1'b1; IdInstr = '0; IdValid = 1'b0; BranchTaken = 1'b0;

        // reset state, including an input-driven jump held off by reset
        step(1'b1, 32'h0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0), "rst_idle");
        step(1'b1, jtype(J), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "rst_jump");
        bubbles(1, "post_rst");

        // lw $1 ; addu $2,$1,$3 -> one load-use stall, later reader forwards from MEM/WB
        step(1'b0, itype(LW, 5'd0, 5'd1), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "lu_lw");
        step(1'b0, rtype(5'd1, 5'd3, 5'd2, ADDU), 1'b1, 1'b0, ev(1, 0, 0, 0, 0), "lu_stall");
        step(1'b0, rtype(5'd1, 5'd3, 5'd2, ADDU), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "lu_release");
        step(1'b0, rtype(5'd1, 5'd3, 5'd4, ADDU), 1'b1, 1'b0, ev(0, 0, 2, 0, 0), "lu_fwd_wb");
        bubbles(3, "lu_drain");

        // addu $1 ; beq $1,$0 taken -> stall wins over jump, then forward + redirect
        step(1'b0, rtype(5'd2, 5'd3, 5'd1, ADDU), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "br_addu");
        step(1'b0, itype(BEQ, 5'd1, 5'd0), 1'b1, 1'b1, ev(1, 0, 0, 0, 0), "br_stall");
        step(1'b0, itype(BEQ, 5'd1, 5'd0), 1'b1, 1'b1, ev(0, 1, 1, 0, 0), "br_taken");
        step(1'b0, itype(BEQ, 5'd1, 5'd1), 1'b1, 1'b0, ev(0, 0, 2, 2, 0), "br_nottaken_wb");

        // jal ; jr $31 -> no stall, link forwarded, two single-cycle redirects
        step(1'b0, jtype(JAL), 1'b1, 1'b0, ev(0, 1, 0, 0, 0), "jal");
        step(1'b0, rtype(5'd31, 5'd0, 5'd0, JR), 1'b1, 1'b0, ev(0, 1, 1, 0, 0), "jr");
        bubbles(2, "jr_drain");

        // writes to $0 never create hazards or forwards
        step(1'b0, rtype(5'd1, 5'd2, 5'd0, ADDU), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "z_addu0");
        step(1'b0, itype(BEQ, 5'd0, 5'd0), 1'b1, 1'b1, ev(0, 1, 0, 0, 0), "z_beq");
        step(1'b0, rtype(5'd0, 5'd0, 5'd3, ADDU), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "z_addu_use0");
        bubbles(3, "z_drain");

        // div ; mflo -> 11 stall cycles, 10 busy cycles
        step(1'b0, rtype(5'd1, 5'd2, 5'd0, DIV), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "div");
        step(1'b0, rtype(5'd0, 5'd0, 5'd4, MFLO), 1'b1, 1'b0, ev(1, 0, 0, 0, 0), "mflo_ex_div");
        for (int i = 0; i < 10; i++)
            step(1'b0, rtype(5'd0, 5'd0, 5'd4, MFLO), 1'b1, 1'b0, ev(1, 0, 0, 0, 1), "mflo_busy");
        step(1'b0, rtype(5'd0, 5'd0, 5'd4, MFLO), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "mflo_issue");
        bubbles(3, "div_drain");

        // mult, then async reset mid-count; mfhi after reset issues unstalled
        step(1'b0, rtype(5'd1, 5'd2, 5'd0, MULT), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "mult");
        step(1'b0, 32'h0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0), "mult_in_ex");
        step(1'b0, rtype(5'd0, 5'd0, 5'd5, MFHI), 1'b1, 1'b0, ev(1, 0, 0, 0, 1), "mfhi_busy");
        step(1'b1, rtype(5'd0, 5'd0, 5'd5, MFHI), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "async_rst");
        step(1'b0, rtype(5'd0, 5'd0, 5'd5, MFHI), 1'b1, 1'b0, ev(0, 0, 0, 0, 0), "mfhi_after_rst");
        bubbles(1, "end");

        // let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
